// File: rtl/sprite_draw_sequencer.sv
// Sprite draw sequencer: walks one sprite's transparency mask two pixels per
// cycle through a dual-port 1-bit ROM and turns opaque, on-screen mask bits
// into frame-buffer pixel-write strobes with screen coordinates.
module sprite_draw_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_sprite,
    input  logic [9:0] cmd_x,
    input  logic [9:0] cmd_y,
    output logic [9:0] rom_addr1,
    output logic [9:0] rom_addr2,
    input  logic       rom_out1,
    input  logic       rom_out2,
    output logic       wr0_en,
    output logic [9:0] wr0_x,
    output logic [9:0] wr0_y,
    output logic       wr1_en,
    output logic [9:0] wr1_x,
    output logic [9:0] wr1_y,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DRAIN1 = 2'd2;
    localparam logic [1:0] S_DRAIN2 = 2'd3;

    localparam logic [10:0] SCREEN_W = 11'd640;
    localparam logic [10:0] SCREEN_H = 11'd480;

    logic [1:0] state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [9:0] base_q, base_d;
    logic [4:0] w_q, w_d;
    logic [4:0] h_q, h_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [9:0] row_start_q, row_start_d;

    logic       a_valid_q, a_valid_d;
    logic [4:0] a_row_q, a_row_d;
    logic [4:0] a_col_q, a_col_d;
    logic       a_pix1_q, a_pix1_d;

    logic       wr0_en_q, wr0_en_d;
    logic [9:0] wr0_x_q, wr0_x_d;
    logic [9:0] wr0_y_q, wr0_y_d;
    logic       wr1_en_q, wr1_en_d;
    logic [9:0] wr1_x_q, wr1_x_d;
    logic [9:0] wr1_y_q, wr1_y_d;

    logic [9:0] tbl_base;
    logic [4:0] tbl_w;
    logic [4:0] tbl_h;
    logic       tbl_valid;

    logic       fetching;
    logic [4:0] col_next;
    logic       row_end;
    logic       last_pair;
    logic [9:0] addr_even;
    logic       pix1_ok;

    logic [10:0] px0;
    logic [10:0] px1;
    logic [10:0] py;
    logic        on_row;

    // Fixed sprite table lookup for the command being offered
    always_comb begin
        tbl_base  = 10'd0;
        tbl_w     = 5'd0;
        tbl_h     = 5'd0;
        tbl_valid = 1'b1;
        case (cmd_sprite)
            2'd0: begin tbl_base = 10'd0;   tbl_w = 5'd12; tbl_h = 5'd17; end
            2'd1: begin tbl_base = 10'd204; tbl_w = 5'd15; tbl_h = 5'd25; end
            2'd2: begin tbl_base = 10'd579; tbl_w = 5'd15; tbl_h = 5'd25; end
            default: tbl_valid = 1'b0;
        endcase
    end

    // Current pair address and whether its odd pixel lies inside the sprite
    always_comb begin
        fetching  = (state_q == S_FETCH);
        addr_even = row_start_q + {5'd0, col_q};
        pix1_ok   = ((col_q + 5'd1) < w_q);
        col_next  = col_q + 5'd2;
        row_end   = (col_next >= w_q);
        last_pair = row_end && (row_q == (h_q - 5'd1));
        rom_addr1 = fetching ? addr_even : 10'd0;
        rom_addr2 = fetching ? (pix1_ok ? (addr_even + 10'd1) : addr_even) : 10'd0;
    end

    // Command latch, row/column walk with running row-start, and state flow
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        base_d      = base_q;
        w_d         = w_q;
        h_d         = h_q;
        row_d       = row_q;
        col_d       = col_q;
        row_start_d = row_start_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x_d         = cmd_x;
                    y_d         = cmd_y;
                    base_d      = tbl_base;
                    w_d         = tbl_w;
                    h_d         = tbl_h;
                    row_d       = 5'd0;
                    col_d       = 5'd0;
                    row_start_d = tbl_base;
                    state_d     = tbl_valid ? S_FETCH : S_DRAIN2;
                end
            end
            S_FETCH: begin
                if (row_end) begin
                    col_d       = 5'd0;
                    row_d       = row_q + 5'd1;
                    row_start_d = row_start_q + {5'd0, w_q};
                end else begin
                    col_d = col_next;
                end
                if (last_pair) begin
                    state_d = S_DRAIN1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Stage A tags the issued pair so it lines up with the ROM data next cycle
    always_comb begin
        a_valid_d = fetching;
        a_row_d   = row_q;
        a_col_d   = col_q;
        a_pix1_d  = pix1_ok;
    end

    // Stage B turns mask bits into clipped screen-space write strobes
    always_comb begin
        px0      = {1'b0, x_q} + {6'd0, a_col_q};
        px1      = px0 + 11'd1;
        py       = {1'b0, y_q} + {6'd0, a_row_q};
        on_row   = (py < SCREEN_H);
        wr0_en_d = a_valid_q & rom_out1 & (px0 < SCREEN_W) & on_row;
        wr1_en_d = a_valid_q & rom_out2 & a_pix1_q & (px1 < SCREEN_W) & on_row;
        wr0_x_d  = px0[9:0];
        wr0_y_d  = py[9:0];
        wr1_x_d  = px1[9:0];
        wr1_y_d  = py[9:0];
    end

    // All state registers; reset aborts any draw and empties the pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            base_q      <= 10'd0;
            w_q         <= 5'd0;
            h_q         <= 5'd0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            row_start_q <= 10'd0;
            a_valid_q   <= 1'b0;
            a_row_q     <= 5'd0;
            a_col_q     <= 5'd0;
            a_pix1_q    <= 1'b0;
            wr0_en_q    <= 1'b0;
            wr0_x_q     <= 10'd0;
            wr0_y_q     <= 10'd0;
            wr1_en_q    <= 1'b0;
            wr1_x_q     <= 10'd0;
            wr1_y_q     <= 10'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            base_q      <= base_d;
            w_q         <= w_d;
            h_q         <= h_d;
            row_q       <= row_d;
            col_q       <= col_d;
            row_start_q <= row_start_d;
            a_valid_q   <= a_valid_d;
            a_row_q     <= a_row_d;
            a_col_q     <= a_col_d;
            a_pix1_q    <= a_pix1_d;
            wr0_en_q    <= wr0_en_d;
            wr0_x_q     <= wr0_x_d;
            wr0_y_q     <= wr0_y_d;
            wr1_en_q    <= wr1_en_d;
            wr1_x_q     <= wr1_x_d;
            wr1_y_q     <= wr1_y_d;
        end
    end

    // Handshake and status decode straight from the state register
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DRAIN2);
        wr0_en    = wr0_en_q;
        wr0_x     = wr0_x_q;
        wr0_y     = wr0_y_q;
        wr1_en    = wr1_en_q;
        wr1_x     = wr1_x_q;
        wr1_y     = wr1_y_q;
    end

    logic unused_base;
    assign unused_base = ^base_q;

endmodule
